uart_host_tx: RTL and testbench

//   Serial transmitter for the host end of the CPU's UART link. Queues bytes from a

---
 rtl/uart_host_tx_pkg.sv | 30 +++
 rtl/uart_host_tx_if.sv | 11 +
 rtl/uart_host_tx_fifo.sv | 60 ++++++
 rtl/uart_host_tx.sv | 169 ++++++++++++++++
 tb/tb_uart_host_tx.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_host_tx_pkg.sv
// Shared definitions for the host-side UART transmitter.
// Contains the FSM state encoding, parity mode constants and the parity helper.
`timescale 1ns/1ps
package uart_host_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Odd parity makes the total count of ones (data plus parity bit) odd.
   function automatic logic parity_of(input int mode, input logic [7:0] data);
      logic bit_value;
      bit_value = 1'b0;
      if (mode == PAR_ODD) begin
         bit_value = ~^data;
      end else if (mode == PAR_EVEN) begin
         bit_value = ^data;
      end
      return bit_value;
   endfunction

endpackage

// File: rtl/uart_host_tx_if.sv
// Byte stream handshake into the UART transmitter.
// The producer uses the master modport and the transmitter uses the slave modport.
`timescale 1ns/1ps
interface uart_host_tx_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_host_tx_fifo.sv
// Single-clock FIFO with synchronous reset, registered count and show-ahead read data.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
`timescale 1ns/1ps
module uart_host_tx_fifo #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] wr_data,
   input  logic          push,
   output logic          full,
   output logic [DW-1:0] rd_data,
   input  logic          pop,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   // Full is taken from the registered count, so a same-cycle pop never frees a slot.
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: rtl/uart_host_tx.sv
// Host-side UART transmitter: queues bytes from a valid/ready stream and sends
// them as start + 8 data bits LSB first + optional parity + 1 or 2 stop bits.
`timescale 1ns/1ps
module uart_host_tx
   import uart_host_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_AW      = 4,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic               clk,
   input  logic               rst,
   uart_host_tx_if.slave      stream,
   output logic               tx,
   output logic               busy,
   output logic [FIFO_AW:0]   fifo_count
);

   localparam int             BW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0]  BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
   localparam logic           LAST_STOP   = 1'(STOP_BITS - 1);

   state_t        state;
   state_t        state_next;
   logic [BW-1:0] baud;
   logic [BW-1:0] baud_next;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_idx_next;
   logic [7:0]    shift_reg;
   logic [7:0]    shift_next;
   logic          par_reg;
   logic          par_next;
   logic          stop_idx;
   logic          stop_idx_next;
   logic          tx_next;
   logic          pop;
   logic [7:0]    fifo_data;
   logic          fifo_full;
   logic          fifo_empty;

   uart_host_tx_fifo #(.DW(8), .AW(FIFO_AW)) fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_data (stream.in_data),
      .push    (stream.in_valid),
      .full    (fifo_full),
      .rd_data (fifo_data),
      .pop     (pop),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign stream.in_ready = !fifo_full;
   assign busy            = (state != ST_IDLE) || (fifo_count != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         baud      <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         par_reg   <= 1'b0;
         stop_idx  <= 1'b0;
         tx        <= 1'b1;
      end else begin
         state     <= state_next;
         baud      <= baud_next;
         bit_idx   <= bit_idx_next;
         shift_reg <= shift_next;
         par_reg   <= par_next;
         stop_idx  <= stop_idx_next;
         tx        <= tx_next;
      end
   end

   // The parity bit is captured at load time because the shift register is consumed.
   always_comb begin
      state_next    = state;
      baud_next     = baud;
      bit_idx_next  = bit_idx;
      shift_next    = shift_reg;
      par_next      = par_reg;
      stop_idx_next = stop_idx;
      tx_next       = tx;
      pop           = 1'b0;
      unique case (state)
         ST_IDLE: begin
            tx_next = 1'b1;
            if (!fifo_empty) begin
               pop        = 1'b1;
               shift_next = fifo_data;
               par_next   = parity_of(PARITY, fifo_data);
               tx_next    = 1'b0;
               baud_next  = BAUD_RELOAD;
               state_next = ST_START;
            end
         end
         ST_START: begin
            if (baud == '0) begin
               tx_next      = shift_reg[0];
               bit_idx_next = 3'd0;
               baud_next    = BAUD_RELOAD;
               state_next   = ST_DATA;
            end else begin
               baud_next = baud - 1'b1;
            end
         end
         ST_DATA: begin
            if (baud == '0) begin
               baud_next = BAUD_RELOAD;
               if (bit_idx == 3'd7) begin
                  if (PARITY != PAR_NONE) begin
                     tx_next    = par_reg;
                     state_next = ST_PARITY;
                  end else begin
                     tx_next       = 1'b1;
                     stop_idx_next = 1'b0;
                     state_next    = ST_STOP;
                  end
               end else begin
                  bit_idx_next = bit_idx + 3'd1;
                  shift_next   = {1'b0, shift_reg[7:1]};
                  tx_next      = shift_reg[1];
               end
            end else begin
               baud_next = baud - 1'b1;
            end
         end
         ST_PARITY: begin
            if (baud == '0) begin
               tx_next       = 1'b1;
               stop_idx_next = 1'b0;
               baud_next     = BAUD_RELOAD;
               state_next    = ST_STOP;
            end else begin
               baud_next = baud - 1'b1;
            end
         end
         ST_STOP: begin
            if (baud == '0) begin
               baud_next = BAUD_RELOAD;
               if (stop_idx == LAST_STOP) begin
                  // Chaining straight into the next start bit leaves no idle gap.
                  if (!fifo_empty) begin
                     pop        = 1'b1;
                     shift_next = fifo_data;
                     par_next   = parity_of(PARITY, fifo_data);
                     tx_next    = 1'b0;
                     state_next = ST_START;
                  end else begin
                     tx_next    = 1'b1;
                     state_next = ST_IDLE;
                  end
               end else begin
                  stop_idx_next = 1'b1;
               end
            end else begin
               baud_next = baud - 1'b1;
            end
         end
         default: begin
            tx_next    = 1'b1;
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_host_tx.sv
// Directed bench for uart_host_tx: four parameter variants share one clock,
// reset and input stream, with a per-variant valid gate and an output mux.
`timescale 1ns/1ps
module tb_uart_host_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic [1:0] sel = 2'd0;
   int         checks = 0;
   int         errors = 0;

   logic       tx0, tx1, tx2, tx3;
   logic       busy0, busy1, busy2, busy3;
   logic [4:0] cnt0, cnt1, cnt2, cnt3;

   uart_host_tx_if s0 ();
   uart_host_tx_if s1 ();
   uart_host_tx_if s2 ();
   uart_host_tx_if s3 ();

   assign s0.in_data  = in_data;
   assign s1.in_data  = in_data;
   assign s2.in_data  = in_data;
   assign s3.in_data  = in_data;
   assign s0.in_valid = in_valid && (sel == 2'd0);
   assign s1.in_valid = in_valid && (sel == 2'd1);
   assign s2.in_valid = in_valid && (sel == 2'd2);
   assign s3.in_valid = in_valid && (sel == 2'd3);

   uart_host_tx #(.CLKS_PER_BIT(4), .FIFO_AW(4), .PARITY(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst(rst), .stream(s0), .tx(tx0), .busy(busy0), .fifo_count(cnt0));
   uart_host_tx #(.CLKS_PER_BIT(4), .FIFO_AW(4), .PARITY(1), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst(rst), .stream(s1), .tx(tx1), .busy(busy1), .fifo_count(cnt1));
   uart_host_tx #(.CLKS_PER_BIT(4), .FIFO_AW(4), .PARITY(2), .STOP_BITS(1)) dut2 (
      .clk(clk), .rst(rst), .stream(s2), .tx(tx2), .busy(busy2), .fifo_count(cnt2));
   uart_host_tx #(.CLKS_PER_BIT(2), .FIFO_AW(4), .PARITY(0), .STOP_BITS(2)) dut3 (
      .clk(clk), .rst(rst), .stream(s3), .tx(tx3), .busy(busy3), .fifo_count(cnt3));

   logic       line;
   logic       busy_m;
   logic       rdy_m;
   logic [4:0] cnt_m;

   always_comb begin
      line   = tx0;
      busy_m = busy0;
      rdy_m  = s0.in_ready;
      cnt_m  = cnt0;
      case (sel)
         2'd1:    begin line = tx1; busy_m = busy1; rdy_m = s1.in_ready; cnt_m = cnt1; end
         2'd2:    begin line = tx2; busy_m = busy2; rdy_m = s2.in_ready; cnt_m = cnt2; end
         2'd3:    begin line = tx3; busy_m = busy3; rdy_m = s3.in_ready; cnt_m = cnt3; end
         default: begin end
      endcase
   end

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic check_cnt(input string name, input logic [4:0] got, input logic [4:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Expects the next tick to show cycle 0 of the frame (start bit) on the selected line.
   task automatic check_frame(input logic [7:0] data, input int has_par, input logic par_bit,
                              input int stops, input int cpb, input string name);
      int   nbits;
      logic e;
      nbits = 9 + has_par + stops;
      for (int b = 0; b < nbits; b++) begin
         if (b == 0) e = 1'b0;
         else if (b <= 8) e = data[b-1];
         else if (has_par != 0 && b == 9) e = par_bit;
         else e = 1'b1;
         for (int c = 0; c < cpb; c++) begin
            tick();
            checks++;
            if (line !== e) begin
               errors++;
               $display("[TB] FAIL %s bit %0d cycle %0d: tx=%b expected %b", name, b, c, line, e);
            end
         end
      end
   endtask

   // Receiver model: waits for a start bit, then samples each bit at its midpoint.
   task automatic rx_byte(input int cpb, input int has_par, input int max_wait,
                          output logic [7:0] data, output logic stop_ok, output logic found);
      int cur;
      int nb;
      int t;
      found   = 1'b0;
      data    = 8'h00;
      stop_ok = 1'b0;
      for (int w = 0; w < max_wait; w++) begin
         tick();
         if (line === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) return;
      cur = 0;
      nb  = 10 + has_par;
      for (int k = 1; k < nb; k++) begin
         t = k * cpb + cpb / 2;
         while (cur < t) begin
            tick();
            cur++;
         end
         if (k <= 8) data[k-1] = line;
         else if (k == nb - 1) stop_ok = (line === 1'b1);
      end
   endtask

   task automatic push_one(input logic [7:0] value);
      in_data  = value;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      for (int k = 0; k < 4; k++) begin
         sel = 2'(k);
         #1;
         check_bit("reset tx", line, 1'b1);
         check_bit("reset busy", busy_m, 1'b0);
         check_bit("reset in_ready", rdy_m, 1'b1);
         check_cnt("reset fifo_count", cnt_m, 5'd0);
      end
      rst = 1'b0;
      sel = 2'd0;
      tick();
   endtask

   task automatic test_single_byte();
      sel = 2'd0;
      push_one(8'h55);
      check_cnt("single count after push", cnt_m, 5'd1);
      check_bit("single tx before start", line, 1'b1);
      check_bit("single busy after push", busy_m, 1'b1);
      check_frame(8'h55, 0, 1'b0, 1, 4, "frame 0x55");
      check_bit("single busy last stop", busy_m, 1'b1);
      tick();
      check_bit("single busy after frame", busy_m, 1'b0);
      check_bit("single tx idle", line, 1'b1);
   endtask

   task automatic test_back_to_back();
      sel      = 2'd0;
      in_data  = 8'hA3;
      in_valid = 1'b1;
      tick();
      check_cnt("b2b count first", cnt_m, 5'd1);
      in_data = 8'h0F;
      fork
         begin
            tick();
            in_data = 8'hFF;
            tick();
            in_valid = 1'b0;
            check_cnt("b2b count peak", cnt_m, 5'd2);
         end
         check_frame(8'hA3, 0, 1'b0, 1, 4, "b2b frame 0xA3");
      join
      check_frame(8'h0F, 0, 1'b0, 1, 4, "b2b frame 0x0F");
      check_cnt("b2b count drain 1", cnt_m, 5'd1);
      check_frame(8'hFF, 0, 1'b0, 1, 4, "b2b frame 0xFF");
      check_cnt("b2b count drain 0", cnt_m, 5'd0);
      tick();
      check_bit("b2b busy end", busy_m, 1'b0);
   endtask

   task automatic test_fifo_full();
      logic [7:0] rx_data [17];
      logic       rx_found [17];
      logic       rx_stop [17];
      logic [7:0] d;
      logic       sok;
      logic       f;
      int         accepted;
      accepted = 0;
      sel      = 2'd0;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               in_data  = 8'h40 + 8'(i);
               in_valid = 1'b1;
               if (rdy_m === 1'b1) accepted++;
               tick();
            end
            in_valid = 1'b0;
            check_bit("full in_ready low", rdy_m, 1'b0);
            check_cnt("full count 16", cnt_m, 5'd16);
            checks++;
            if (accepted != 17) begin
               errors++;
               $display("[TB] FAIL full accepted: got %0d expected 17", accepted);
            end
         end
         begin
            for (int j = 0; j < 17; j++) begin
               rx_byte(4, 0, 200, d, sok, f);
               rx_data[j]  = d;
               rx_stop[j]  = sok;
               rx_found[j] = f;
            end
         end
      join
      for (int j = 0; j < 17; j++) begin
         checks++;
         if (rx_found[j] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full rx %0d: no start bit, expected 0x%02h", j, 8'h40 + 8'(j));
         end else if (rx_data[j] !== 8'h40 + 8'(j) || rx_stop[j] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full rx %0d: got 0x%02h stop %b expected 0x%02h stop 1",
                     j, rx_data[j], rx_stop[j], 8'h40 + 8'(j));
         end
      end
      rx_byte(4, 0, 80, d, sok, f);
      check_bit("full no extra frame", f, 1'b0);
      check_bit("full busy end", busy_m, 1'b0);
      check_cnt("full count end", cnt_m, 5'd0);
   endtask

   task automatic test_parity();
      sel = 2'd1;
      push_one(8'h07);
      check_frame(8'h07, 1, 1'b0, 1, 4, "odd parity 0x07");
      check_bit("odd busy last cycle", busy_m, 1'b1);
      tick();
      check_bit("odd busy after 44", busy_m, 1'b0);
      sel = 2'd2;
      push_one(8'h07);
      check_frame(8'h07, 1, 1'b1, 1, 4, "even parity 0x07");
      check_bit("even busy last cycle", busy_m, 1'b1);
      tick();
      check_bit("even busy after 44", busy_m, 1'b0);
   endtask

   task automatic test_reset_mid_frame();
      sel      = 2'd0;
      in_data  = 8'h3C;
      in_valid = 1'b1;
      tick();
      in_data = 8'h99;
      tick();
      in_valid = 1'b0;
      check_bit("midrst start bit", line, 1'b0);
      check_cnt("midrst queued", cnt_m, 5'd1);
      repeat (17) tick();
      check_bit("midrst data bit 3", line, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_bit("midrst tx high", line, 1'b1);
      check_cnt("midrst count cleared", cnt_m, 5'd0);
      check_bit("midrst busy", busy_m, 1'b0);
      check_bit("midrst in_ready", rdy_m, 1'b1);
      tick();
      push_one(8'h81);
      check_frame(8'h81, 0, 1'b0, 1, 4, "post reset 0x81");
      tick();
      check_bit("midrst busy end", busy_m, 1'b0);
   endtask

   task automatic test_two_stop_bits();
      logic [7:0] d;
      logic       sok;
      logic       f;
      sel = 2'd3;
      push_one(8'h00);
      check_frame(8'h00, 0, 1'b0, 2, 2, "two stop 0x00");
      tick();
      check_bit("two stop busy after 22", busy_m, 1'b0);
      push_one(8'h00);
      rx_byte(2, 0, 20, d, sok, f);
      check_bit("two stop rx found", f, 1'b1);
      check_cnt("two stop rx data", {1'b0, d[3:0]}, 5'd0);
      check_cnt("two stop rx data high", {1'b0, d[7:4]}, 5'd0);
      check_bit("two stop rx stop", sok, 1'b1);
      repeat (4) tick();
      check_bit("two stop idle", busy_m, 1'b0);
   endtask

   initial begin
      $display("[TB] starting uart_host_tx bench");
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_fifo_full();
      test_parity();
      test_reset_mid_frame();
      test_two_stop_bits();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
